dot_score: RTL

- Consumer of the per-dot eaten vector produced by the dot tracker.
- Detects newly eaten dots, queues them, and accumulates a saturating BCD score one digit per cycle.
- Tracks the number of remaining dots and raises a held level-clear flag when all dots are eaten.
- Feeds the score/HUD renderer and the top-level game FSM.

---
 rtl/dot_score_pkg.sv | 26 ++
 rtl/dot_score_prio_enc.sv | 23 ++
 rtl/dot_score.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dot_score_pkg.sv
// Shared types and BCD helpers for the dot scoring block.
package dot_score_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ADD   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] LEVEL_BONUS_BCD = 16'h0100;

    // Returns {carry_out, digit}; the raw sum is at most 9 + 9 + 1 = 19.
    function automatic logic [4:0] bcd_digit_add(input bcd_digit_t a, input bcd_digit_t b,
                                                 input logic cin);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (sum > 5'd9) begin
            return {1'b1, 4'(sum - 5'd10)};
        end
        return {1'b0, sum[3:0]};
    endfunction

endpackage

// File: rtl/dot_score_prio_enc.sv
// Lowest-set-bit encoder: index, valid and a one-hot mask of the selected bit.
module dot_prio_enc #(
    parameter int NUM_DOTS = 32
) (
    input  logic [NUM_DOTS-1:0] req,
    output logic [5:0]          index,
    output logic                valid,
    output logic [NUM_DOTS-1:0] clr_mask
);

    always_comb begin
        index = '0;
        valid = |req;
        // Two's-complement trick isolates the lowest set bit.
        clr_mask = req & (~req + NUM_DOTS'(1));
        for (int i = NUM_DOTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = 6'(i);
            end
        end
    end

endmodule

// File: rtl/dot_score.sv
// Queues newly eaten dots and accumulates a saturating BCD score one digit per cycle.
// Optional level bonus pass on level clear: define DOT_SCORE_LEVEL_BONUS_EN.
module dot_score
    import dot_score_pkg::*;
#(
    parameter int                        NUM_DOTS       = 32,
    parameter int                        SCORE_DIGITS   = 4,
    parameter logic [4*SCORE_DIGITS-1:0] DOT_POINTS_BCD = 16'h0010
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NUM_DOTS-1:0]       eaten,
    input  logic                      clear_ack,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [5:0]                dots_remaining,
    output logic                      busy,
    output logic                      level_clear,
    output logic [1:0]                dbg_state,
    output logic [5:0]                dbg_dot_index
);

    localparam int DW = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;

    state_t                state, state_nxt;
    logic [NUM_DOTS-1:0]   prev_eaten, pending, new_bits, clr_mask, scan_clr;
    logic [5:0]            enc_index, free_count;
    logic                  enc_valid, carry, last_digit;
    logic [DW-1:0]         digit_idx;
    bcd_digit_t            addend;
    logic [4:0]            add_res;

`ifdef DOT_SCORE_LEVEL_BONUS_EN
    localparam logic [4*SCORE_DIGITS+15:0] BONUS_EXT = {{(4*SCORE_DIGITS){1'b0}}, LEVEL_BONUS_BCD};
    logic bonus_pass;
`endif

    dot_prio_enc #(.NUM_DOTS(NUM_DOTS)) u_enc (
        .req      (pending),
        .index    (enc_index),
        .valid    (enc_valid),
        .clr_mask (clr_mask)
    );

    assign new_bits      = eaten & ~prev_eaten;
    assign scan_clr      = (state == SCAN) ? clr_mask : '0;
    assign last_digit    = (digit_idx == DW'(SCORE_DIGITS - 1));
    assign busy          = (state != IDLE);
    // level_clear is a held request: it stays high until the game FSM answers
    // with clear_ack; clear_ack seen in any other state is dropped.
    assign level_clear   = (state == CLEAR);
    assign dbg_state     = state;

    always_comb begin
        free_count = '0;
        for (int i = 0; i < NUM_DOTS; i++) begin
            free_count = free_count + {5'b00000, ~eaten[i]};
        end
    end

    always_comb begin
        addend = DOT_POINTS_BCD[4*digit_idx +: 4];
`ifdef DOT_SCORE_LEVEL_BONUS_EN
        if (bonus_pass) begin
            addend = BONUS_EXT[4*digit_idx +: 4];
        end
`endif
        add_res = bcd_digit_add(score_bcd[4*digit_idx +: 4], addend, carry);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nxt = SCAN;
                end else if (dots_remaining == 6'd0) begin
`ifdef DOT_SCORE_LEVEL_BONUS_EN
                    state_nxt = ADD;
`else
                    state_nxt = CLEAR;
`endif
                end
            end
            SCAN: state_nxt = ADD;
            ADD: begin
                if (last_digit) begin
`ifdef DOT_SCORE_LEVEL_BONUS_EN
                    state_nxt = bonus_pass ? CLEAR : IDLE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            CLEAR: begin
                if (clear_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            prev_eaten     <= '0;
            pending        <= '0;
            score_bcd      <= '0;
            dots_remaining <= 6'(NUM_DOTS);
            digit_idx      <= '0;
            carry          <= 1'b0;
            dbg_dot_index  <= '0;
`ifdef DOT_SCORE_LEVEL_BONUS_EN
            bonus_pass     <= 1'b0;
`endif
        end else begin
            prev_eaten <= eaten;
            if (state == CLEAR && clear_ack) begin
                pending        <= '0;
                dots_remaining <= free_count;
            end else begin
                // A new edge on the bit being cleared wins over the clear.
                pending <= (pending & ~scan_clr) | new_bits;
                if (state == SCAN && enc_valid && dots_remaining != 6'd0) begin
                    dots_remaining <= dots_remaining - 6'd1;
                end
            end
            case (state)
`ifdef DOT_SCORE_LEVEL_BONUS_EN
                IDLE: begin
                    if (!(|pending) && dots_remaining == 6'd0) begin
                        bonus_pass <= 1'b1;
                        digit_idx  <= '0;
                        carry      <= 1'b0;
                    end
                end
`endif
                SCAN: begin
                    digit_idx     <= '0;
                    carry         <= 1'b0;
                    dbg_dot_index <= enc_index;
`ifdef DOT_SCORE_LEVEL_BONUS_EN
                    bonus_pass    <= 1'b0;
`endif
                end
                ADD: begin
                    score_bcd[4*digit_idx +: 4] <= add_res[3:0];
                    carry     <= add_res[4];
                    digit_idx <= digit_idx + 1'b1;
                    if (last_digit && add_res[4]) begin
                        score_bcd <= {SCORE_DIGITS{4'h9}};
                    end
`ifdef DOT_SCORE_LEVEL_BONUS_EN
                    if (last_digit) begin
                        bonus_pass <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
